// File: rtl/bsg_fifo_ctrl_pkg.sv
// Shared helpers for the small 1r1w FIFO controller: pointer and count
// widths, plus the minimum legal entry count.
package bsg_fifo_ctrl_pkg;

    // Fewer than two entries would let the read and write pointers collide
    // on every cycle; the controller refuses to elaborate below this.
    localparam int min_els_lp = 2;

    // Pointer width: at least one bit even for degenerate sizes.
    function automatic int ptr_width(input int els);
        int w;
        w = $clog2(els);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    // Count width must hold the value els itself (the full condition).
    function automatic int count_width(input int els);
        return $clog2(els + 1);
    endfunction

endpackage

// File: rtl/bsg_circular_ptr_wrap_rn.sv
// Circular pointer over slots_p entries with explicit wrap, so any slot
// count (not only powers of two) steps 0..slots_p-1 and back to 0.
module bsg_circular_ptr_wrap_rn
    import bsg_fifo_ctrl_pkg::*;
#(
    parameter int  slots_p      = 2,
    localparam int ptr_width_lp = ptr_width(slots_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    add_i,
    output logic [ptr_width_lp-1:0] ptr_o
);

    localparam logic [ptr_width_lp-1:0] last_lp = ptr_width_lp'(slots_p - 1);

    logic [ptr_width_lp-1:0] ptr_q;
    logic [ptr_width_lp-1:0] ptr_d;

    // Advance by one on add_i, wrapping from the last slot to zero.
    always_comb begin
        ptr_d = ptr_q;
        if (add_i) begin
            ptr_d = (ptr_q == last_lp) ? '0 : ptr_q + ptr_width_lp'(1);
        end
    end

    // Pointer register, cleared asynchronously.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/bsg_fifo_1r1w_small_ctrl.sv
// Ready/valid-in, valid/yumi-out controller for a small 1r1w FIFO built on
// an external bsg_mem_1r1w_synth. Owns pointers, occupancy and port strobes.
// Optional sticky protocol-error flag: define BSG_FIFO_CTRL_ERR_EN.
module bsg_fifo_1r1w_small_ctrl
    import bsg_fifo_ctrl_pkg::*;
#(
    parameter int  width_p        = 16,
    parameter int  els_p          = 2,
    localparam int ptr_width_lp   = ptr_width(els_p),
    localparam int count_width_lp = count_width(els_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,

    input  logic                      v_i,
    input  logic [width_p-1:0]        data_i,
    output logic                      ready_o,

    output logic                      v_o,
    output logic [width_p-1:0]        data_o,
    input  logic                      yumi_i,

    output logic                      mem_w_v_o,
    output logic [ptr_width_lp-1:0]   mem_w_addr_o,
    output logic [width_p-1:0]        mem_w_data_o,
    output logic                      mem_w_reset_o,
    output logic                      mem_r_v_o,
    output logic [ptr_width_lp-1:0]   mem_r_addr_o,
    input  logic [width_p-1:0]        mem_r_data_i,

    output logic [count_width_lp-1:0] count_o,
    output logic                      err_o
);

    if (els_p < min_els_lp) begin : g_els_check
        $error("bsg_fifo_1r1w_small_ctrl: els_p must be at least 2");
    end

    localparam logic [count_width_lp-1:0] full_count_lp = count_width_lp'(els_p);

    logic [count_width_lp-1:0] count_q;
    logic [count_width_lp-1:0] count_d;
    logic [ptr_width_lp-1:0]   wptr_r;
    logic [ptr_width_lp-1:0]   rptr_r;
    logic                      enq;
    logic                      deq;

    // Enqueue is refused whenever full, even with a dequeue in the same
    // cycle: this keeps the write address off the live read address.
    assign ready_o = (count_q != full_count_lp);
    assign v_o     = (count_q != '0);
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    assign mem_w_v_o     = enq;
    assign mem_w_addr_o  = wptr_r;
    assign mem_w_data_o  = data_i;
    assign mem_w_reset_o = ~reset_n_i;
    assign mem_r_v_o     = v_o;
    assign mem_r_addr_o  = rptr_r;
    assign data_o        = mem_r_data_i;
    assign count_o       = count_q;

    bsg_circular_ptr_wrap_rn #(.slots_p(els_p)) u_wptr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .add_i     (enq),
        .ptr_o     (wptr_r)
    );

    bsg_circular_ptr_wrap_rn #(.slots_p(els_p)) u_rptr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .add_i     (deq),
        .ptr_o     (rptr_r)
    );

    // Occupancy: +1 on enqueue only, -1 on dequeue only, else hold.
    always_comb begin
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + count_width_lp'(1);
            2'b01:   count_d = count_q - count_width_lp'(1);
            default: count_d = count_q;
        endcase
    end

    // Occupancy register, cleared asynchronously.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

`ifdef BSG_FIFO_CTRL_ERR_EN
    logic err_q;
    logic err_d;

    // Sticky flag for dequeue-while-empty or enqueue-while-full attempts.
    always_comb begin
        err_d = err_q | (yumi_i & ~v_o) | (v_i & ~ready_o);
    end

    // Error register, only cleared by reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: doc/bsg_fifo_1r1w_small_ctrl.md
Name: bsg_fifo_1r1w_small_ctrl

Overview:
- Ready/valid-in, valid/yumi-out FIFO controller that sequences one bsg_mem_1r1w_synth instance: 2 entries, 16 bits, read_write_same_addr_p0.
- Owns the write/read pointers, occupancy count, full/empty flags and memory port strobes. The memory stays a separate instance; this block only drives it.
- Used as the small decoupling buffer on bp_quad inter-tile links.

Parameters:
- width_p, 16, data width; must match the memory width_p.
- els_p, 2, number of entries; must be ≥2 and may be any value (not only a power of 2); must match the memory els_p.
- ptr_width_lp, max(1,$clog2(els_p)), derived; not overridable.

Ports:
- clk_i  in  1  sole clock; also drives the memory w_clk_i.
- reset_n_i  in  1  asynchronous, active-low reset.
- v_i  in  1  enqueue request.
- data_i  in  width_p  enqueue data.
- ready_o  out  1  enqueue accepted when v_i&ready_o.
- v_o  out  1  head entry valid.
- data_o  out  width_p  head entry data.
- yumi_i  in  1  dequeue; legal only when v_o=1.
- mem_w_v_o  out  1  to memory w_v_i.
- mem_w_addr_o  out  ptr_width_lp  to memory w_addr_i.
- mem_w_data_o  out  width_p  to memory w_data_i.
- mem_w_reset_o  out  1  to memory w_reset_i; equals ~reset_n_i.
- mem_r_v_o  out  1  to memory r_v_i.
- mem_r_addr_o  out  ptr_width_lp  to memory r_addr_i.
- mem_r_data_i  in  width_p  from memory r_data_o.
- count_o  out  $clog2(els_p+1)  occupancy.
- err_o  out  1  sticky protocol error; see Optional Feature.

Behaviour:
- State registers: wptr_r, rptr_r, count_r, err_r. All are cleared asynchronously when reset_n_i=0. Memory contents are not cleared.
- Reset values: ready_o=1, v_o=0, count_o=0, err_o=0, mem_w_v_o=0, mem_r_v_o=0, both addresses=0.
- enq = v_i & ready_o; deq = yumi_i & v_o.
- ready_o = (count_r != els_p). No enqueue is accepted when full, even if deq fires in the same cycle; this preserves read_write_same_addr_p0.
- v_o = (count_r != 0). data_o = mem_r_data_i (combinational through the memory read mux). mem_r_v_o = v_o. mem_r_addr_o = rptr_r.
- mem_w_v_o = enq; mem_w_addr_o = wptr_r; mem_w_data_o = data_i.
- Pointer update: on enq, wptr_r ← (wptr_r==els_p-1) ? 0 : wptr_r+1. rptr_r updates the same way on deq. Wrap is explicit, so non-power-of-2 els_p is correct.
- Count update:
  - enq only: +1.
  - deq only: -1.
  - enq and deq together: unchanged.
  - Neither: hold.
- Latency:
  - Enqueue to v_o: 1 cycle. Data written at edge N is visible on data_o after edge N.
  - Dequeue to next head: 1 cycle.
  - No bypass path.
- Empty with enq in the same cycle: wptr==rptr, but mem_r_v_o=0, so no same-address conflict exists.
- yumi_i while v_o=0: ignored. Pointers and count are unchanged.
- v_i while full: ignored; data is dropped by protocol.
- Reset asserted mid-transfer: all state clears immediately and asynchronously. Any in-flight enqueue in that cycle is lost.
- Reset deassertion must be synchronized externally to clk_i.

Optional Feature:
- Macro: BSG_FIFO_CTRL_ERR_EN.
- When defined:
  - err_r sets on (yumi_i & ~v_o) or (v_i & ~ready_o).
  - Once set, it stays set until reset_n_i=0.
  - err_o = err_r.
- When undefined:
  - err_o is tied to 0 and the err_r flop is not instantiated.
  - All other behaviour is identical.

Decomposition:
- Package bsg_fifo_ctrl_pkg holds:
  - the ptr-width helper function;
  - the count-width helper function;
  - the localparam for the els_p≥2 check (elaboration error otherwise).
- One sub-module, bsg_circular_ptr_wrap_rn (params slots_p, async active-low reset, input add_i, output ptr_o).
- It is instantiated twice: once for wptr and once for rptr.
- The count stays in the top level.

Test Plan:
- Reset: drive reset_n_i=0 mid-run with count=2. Required immediately (before any edge): v_o=0, ready_o=1, count_o=0, both addresses=0.
- Fill/drain: enqueue 0xA5A5 then 0x5A5A. Required: count 1 then 2, ready_o=0. Then yumi twice: data_o=0xA5A5 then 0x5A5A, v_o=0 after the second yumi.
- Simultaneous enq+deq at count=1: count stays 1. Pointers advance; wptr and rptr each wrap 1→0 at els_p=2. Data order is preserved over 100 random cycles against a scoreboard.
- Full with v_i=1 and yumi_i=1: the deq occurs, the enq is refused, mem_w_v_o=0, count becomes 1.
- With BSG_FIFO_CTRL_ERR_EN defined: yumi_i=1 while empty → err_o=1 next cycle, remaining 1 after further legal traffic. Without the macro: err_o=0 in the same stimulus.
- els_p=3 build: 7 enqueue/dequeue pairs. Required: wrap sequence 0,1,2,0 and correct data for every pair.
